// File: rtl/phys_free_list.sv
// phys_free_list: physical register tag allocator for the rename stage.
//
// Holds the 30 allocatable tags (2..31) in a circular FIFO. A speculative
// head serves up to two allocations per cycle, a commit head follows
// retirement, and a flush rolls the speculative head back to the commit head.
// Tags 0 and 1 are constant registers and are never handed out or accepted.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   alloc_req    per-lane allocation request (lane 0 is older)
//   alloc_ok     high when at least two tags are speculatively free
//   alloc_addrs  combinational tags offered to lanes 0/1 ([5i +: 5])
//   commit_cnt   number of allocations retiring this cycle (0..2)
//   free_valid   per-lane free strobe from retirement
//   free_addrs   tags being freed ([5i +: 5])
//   flush        misprediction recovery
//   free_count   current speculative free count
//   err          sticky protocol-violation flag
module phys_free_list #(
    parameter int INIT_MAPPED = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] alloc_req,
    output logic       alloc_ok,
    output logic [9:0] alloc_addrs,
    input  logic [1:0] commit_cnt,
    input  logic [1:0] free_valid,
    input  logic [9:0] free_addrs,
    input  logic       flush,
    output logic [4:0] free_count,
    output logic       err
);

    localparam int DEPTH     = 30;
    localparam int INIT_FREE = DEPTH - INIT_MAPPED;

    logic [4:0] fifo_r [0:DEPTH-1];
    logic [4:0] spec_head_r;
    logic [4:0] commit_head_r;
    logic [4:0] tail_r;
    logic [4:0] spec_count_r;
    logic [4:0] commit_count_r;
    logic       alloc_ok_r;
    logic       err_r;

    logic [4:0] lane1_idx_s;
    logic [1:0] nalloc_s;
    logic [4:0] outstanding_s;
    logic       commit_bad_s;
    logic [1:0] commit_eff_s;
    logic [4:0] room_s;
    logic       cand0_s;
    logic       cand1_s;
    logic       take0_s;
    logic       take1_s;
    logic       overflow_s;
    logic [1:0] nfree_s;
    logic [4:0] wr1_idx_s;
    logic [4:0] commit_head_nxt_s;
    logic [4:0] commit_count_nxt_s;
    logic [4:0] tail_nxt_s;
    logic [4:0] spec_head_nxt_s;
    logic [4:0] spec_count_nxt_s;

    // Pointer advance modulo the 30-entry ring (not modulo 32).
    function automatic logic [4:0] ptr_add(input logic [4:0] p, input logic [1:0] n);
        logic [5:0] s;
        s = {1'b0, p} + {4'b0000, n};
        if (s >= 6'd30) begin
            s = s - 6'd30;
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    assign alloc_ok    = alloc_ok_r;
    assign free_count  = spec_count_r;
    assign err         = err_r;
    // A lone lane-1 request takes the head entry, hence the offset by alloc_req[0].
    assign lane1_idx_s = ptr_add(spec_head_r, {1'b0, alloc_req[0]});
    assign alloc_addrs = {fifo_r[lane1_idx_s], fifo_r[spec_head_r]};

    // Next-state computation for pointers, counts, frees and violation detection.
    always_comb begin
        nalloc_s = 2'd0;
        if (alloc_ok_r && !flush) begin
            nalloc_s = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
        end else begin
            nalloc_s = 2'd0;
        end

        // Only allocations older than this cycle can retire; clamp anything beyond.
        outstanding_s = commit_count_r - spec_count_r;
        commit_bad_s  = ({3'b000, commit_cnt} > outstanding_s);
        if (commit_bad_s) begin
            commit_eff_s = outstanding_s[1:0];
        end else begin
            commit_eff_s = commit_cnt;
        end

        // Free slots left in the ring once this cycle's commits are applied.
        room_s  = 5'd30 - commit_count_r + {3'b000, commit_eff_s};
        cand0_s = free_valid[0] && (free_addrs[4:0] >= 5'd2);
        cand1_s = free_valid[1] && (free_addrs[9:5] >= 5'd2);
        take0_s = cand0_s && (room_s >= 5'd1);
        take1_s = cand1_s && (room_s >= (take0_s ? 5'd2 : 5'd1));
        overflow_s = (cand0_s && !take0_s) || (cand1_s && !take1_s);
        nfree_s    = {1'b0, take0_s} + {1'b0, take1_s};
        wr1_idx_s  = take0_s ? ptr_add(tail_r, 2'd1) : tail_r;

        commit_head_nxt_s  = ptr_add(commit_head_r, commit_eff_s);
        commit_count_nxt_s = commit_count_r - {3'b000, commit_eff_s} + {3'b000, nfree_s};
        tail_nxt_s         = ptr_add(tail_r, nfree_s);

        if (flush) begin
            spec_head_nxt_s  = commit_head_nxt_s;
            spec_count_nxt_s = commit_count_nxt_s;
        end else begin
            spec_head_nxt_s  = ptr_add(spec_head_r, nalloc_s);
            spec_count_nxt_s = spec_count_r - {3'b000, nalloc_s} + {3'b000, nfree_s};
        end
    end

    // Tag storage: reset image of the initially free tags, then writes at tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= (i < INIT_FREE) ? 5'(INIT_MAPPED + 2 + i) : 5'd0;
            end
        end else begin
            if (take0_s) begin
                fifo_r[tail_r] <= free_addrs[4:0];
            end
            if (take1_s) begin
                fifo_r[wr1_idx_s] <= free_addrs[9:5];
            end
        end
    end

    // Pointer, count, allocation-ready and sticky error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_head_r    <= 5'd0;
            commit_head_r  <= 5'd0;
            tail_r         <= 5'(INIT_FREE % DEPTH);
            spec_count_r   <= 5'(INIT_FREE);
            commit_count_r <= 5'(INIT_FREE);
            alloc_ok_r     <= (INIT_FREE >= 2);
            err_r          <= 1'b0;
        end else begin
            spec_head_r    <= spec_head_nxt_s;
            commit_head_r  <= commit_head_nxt_s;
            tail_r         <= tail_nxt_s;
            spec_count_r   <= spec_count_nxt_s;
            commit_count_r <= commit_count_nxt_s;
            alloc_ok_r     <= (spec_count_nxt_s >= 5'd2);
            err_r          <= err_r | commit_bad_s | overflow_s;
        end
    end

endmodule

// File: doc/phys_free_list.md
# phys_free_list

Allocator of physical register indices for the rename stage; it sits directly upstream of `phys_reg_file` and supplies the 5-bit destination tags that later index its write and read ports. It holds the 30 allocatable tags (2..31) in a circular buffer. Tags 0 and 1 are the constant registers and are never allocated or freed. A speculative head serves rename, a commit head tracks retirement, and a flush rolls the speculative head back to the commit head.

## Interface
- `INIT_MAPPED`, default 6: tags 2..INIT_MAPPED+1 are owned by the reset rename map. They are not free at reset.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `alloc_req` input 2: per-lane allocation request. Lane 0 is the older lane.
- `alloc_ok` output 1: asserted when `spec_count >= 2`.
- `alloc_addrs` output 10: combinational allocated tags. Lane i occupies bits [5i +: 5].
- `commit_cnt` input 2: number of allocations retiring this cycle, 0..2.
- `free_valid` input 2: per-lane free strobe from retirement.
- `free_addrs` input 10: tags to free. Lane i occupies bits [5i +: 5].
- `flush` input 1: misprediction recovery.
- `free_count` output 5: current `spec_count`.
- `err` output 1: sticky protocol-violation flag.

## Operation
- State:
  - `fifo[0..29]`, 5 bits per entry.
  - `spec_head`, `commit_head` and `tail`, each in the range 0..29. They wrap from 29 to 0 and are never compared modulo 32.
  - `spec_count` and `commit_count`, each 0..30.
- Reset (async, `rst` low):
  - `fifo[i] = INIT_MAPPED+2+i` for i < 30-INIT_MAPPED. Remaining entries are 0.
  - `spec_head = commit_head = 0`.
  - `tail = 30-INIT_MAPPED`.
  - `spec_count = commit_count = 30-INIT_MAPPED`.
  - `err = 0`.
  - Outputs with the default parameter: `free_count = 24`, `alloc_ok = 1`, `alloc_addrs = {5'd9, 5'd8}`.
- Allocation:
  - `alloc_addrs` lane 0 = `fifo[spec_head]`.
  - `alloc_addrs` lane 1 = `fifo[spec_head + alloc_req[0]]`. A lone lane-1 request therefore receives `fifo[spec_head]`.
  - `nalloc = popcount(alloc_req)` when `alloc_ok` is high and `flush` is low, otherwise 0.
  - Allocation is all-or-nothing: when `alloc_ok` is low, requests are ignored and nothing pops.
  - `spec_head` advances by `nalloc`.
- Free:
  - Each valid lane with tag >= 2 is written at `tail`, then `tail+1`, in lane order.
  - Tags 0 and 1 are silently dropped.
  - `nfree` = number of accepted lanes. `tail` advances by `nfree`.
- Commit: `commit_head` advances by `commit_cnt`.
- Count update, normal cycle:
  - `commit_count' = commit_count - commit_cnt + nfree`.
  - `spec_count' = spec_count - nalloc + nfree`.
- Count update, on `flush`: `spec_head' = commit_head'` and `spec_count' = commit_count'`. Commits and frees in the flush cycle still apply.
- `err` sets, and stays set until reset, when any of these occur:
  - `commit_count + nfree - commit_cnt > 30`. The frees causing overflow are dropped.
  - `commit_cnt` exceeds the outstanding allocations, `commit_count - spec_count`. The commit is clamped to the outstanding count.

## Timing
- Tags on `alloc_addrs` are valid in the same cycle as `alloc_req`. The pop takes effect at the next rising edge.
- `alloc_ok` and `free_count` come from registered state only; there is no combinational path from `free_valid` or `flush`. A tag freed in cycle N is allocatable in cycle N+1 at the earliest.
- Simultaneous alloc, free, commit and flush in one cycle are all legal, and the update order is defined by the formulas above.
- `alloc_ok` deasserts when `spec_count` is 1, even for a single-lane request.
- Reset mid-operation discards all state immediately and returns to the reset image.

## Test plan
- Reset release with default parameter -> `free_count = 24`, `alloc_ok = 1`, `alloc_addrs = {9, 8}`, `err = 0`.
- `alloc_req = 2'b11` for one cycle -> next cycle `free_count = 22` and lane 0 = 10. Then `alloc_req = 2'b10` -> lane 1 presents 10, and next cycle lane 0 = 11.
- Allocate 23 tags, then request one more with `free_count = 1` -> `alloc_ok = 0`, no pop, and `free_count` stays 1. Then free tags 5 and 0 -> only 5 is accepted, `free_count = 2` next cycle, `alloc_ok = 1`.
- Wrap-around:
  - Cycle enough frees and allocations that `tail` passes index 29.
  - Required: the tag written at index 29 is followed by the one at index 0, and allocation returns them in FIFO order.
- Flush recovery:
  - Allocate 8,9 and commit them (`commit_cnt = 2`). Allocate 10,11, then assert `flush`.
  - Required: next cycle `alloc_addrs` lane 0 = 10 and `free_count` equals the post-commit count.
- Violations:
  - Free two extra tags with the list full (30 entries) -> `err = 1` and `free_count` stays 30.
  - With `err` already set, `commit_cnt = 2` and no outstanding allocations -> `err` stays 1 and `commit_head` is unchanged.
